// File: rtl/fifo_reader_pkg.sv
// Shared types and constants for the FIFO reader: FSM states, skid-buffer depth
// and the width of the delivered-word counter.
package fifo_reader_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    ERROR = 2'd2
  } state_t;

  localparam int BUF_DEPTH = 3;
  localparam int POP_CNT_W = 16;

endpackage

// File: rtl/fifo_reader_buf.sv
// Three-entry in-order buffer; entry 0 is the head and drives data directly so the
// output word is always a register.
module fifo_reader_buf
  import fifo_reader_pkg::*;
#(
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic [DATA_W-1:0] push_data,
  input  logic              pop,
  output logic [DATA_W-1:0] data,
  output logic [1:0]        occ
);

  logic [DATA_W-1:0] ent [BUF_DEPTH];
  logic [DATA_W-1:0] nxt [BUF_DEPTH];
  logic              pop_ok;
  logic [1:0]        idx;

  assign pop_ok = pop && (occ != 2'd0);
  // A push lands behind the last entry that survives this edge's pop.
  assign idx    = occ - {1'b0, pop_ok};

  always_comb begin
    nxt = ent;
    if (pop_ok) begin
      nxt[0] = ent[1];
      nxt[1] = ent[2];
    end
    if (push) begin
      case (idx)
        2'd0:    nxt[0] = push_data;
        2'd1:    nxt[1] = push_data;
        default: nxt[2] = push_data;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      occ    <= 2'd0;
      ent[0] <= '0;
    end else begin
      occ    <= occ + {1'b0, push} - {1'b0, pop_ok};
      ent[0] <= nxt[0];
    end
  end

  always_ff @(posedge clk) begin
    ent[1] <= nxt[1];
    ent[2] <= nxt[2];
  end

  assign data = ent[0];

endmodule

// File: rtl/fifo_reader.sv
// Credit-based FIFO drain into a valid/ready stream with underflow error handling.
// Optional delivered-word counter enabled by macro FIFO_READER_STATS_EN.
module fifo_reader
  import fifo_reader_pkg::*;
#(
  parameter int FIFO_WIDTH = 16,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  drain_en,
  input  logic                  clr_err,
  input  logic                  fifo_empty,
  input  logic [FIFO_WIDTH-1:0] fifo_data_out,
  input  logic                  fifo_underflow,
  output logic                  fifo_rd_en,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [FIFO_WIDTH-1:0] m_data,
  output logic                  err_underflow,
  output logic [POP_CNT_W-1:0]  pop_count
);

  if (FIFO_DEPTH < 1) begin : g_bad_depth
    $error("FIFO_DEPTH must be at least 1");
  end

  state_t     state;
  logic       inflight;
  logic [1:0] occ;
  logic       push;
  logic       pop;
  logic       uf_cap;

  // clr_err wins over an underflow returning in the same cycle.
  assign uf_cap = inflight && fifo_underflow && !clr_err;
  assign push   = inflight && !fifo_underflow;
  assign pop    = m_valid && m_ready;

  assign m_valid    = (occ != 2'd0) && !rst;
  assign fifo_rd_en = !rst && (state == RUN) && drain_en && !fifo_empty &&
                      (({1'b0, occ} + {2'b0, inflight}) < 3'(BUF_DEPTH));

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      inflight      <= 1'b0;
      err_underflow <= 1'b0;
    end else begin
      inflight <= fifo_rd_en;
      if (clr_err)     err_underflow <= 1'b0;
      else if (uf_cap) err_underflow <= 1'b1;
      case (state)
        IDLE:    if (uf_cap) state <= ERROR;
                 else if (drain_en) state <= RUN;
        RUN:     if (uf_cap) state <= ERROR;
                 else if (!drain_en) state <= IDLE;
        ERROR:   if (clr_err) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  fifo_reader_buf #(
    .DATA_W (FIFO_WIDTH)
  ) u_buf (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_data (fifo_data_out),
    .pop       (pop),
    .data      (m_data),
    .occ       (occ)
  );

`ifdef FIFO_READER_STATS_EN
  function automatic logic [POP_CNT_W-1:0] sat_inc(input logic [POP_CNT_W-1:0] v);
    return (v == '1) ? v : v + 1'b1;
  endfunction

  logic [POP_CNT_W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst)      cnt <= '0;
    else if (pop) cnt <= sat_inc(cnt);
  end

  assign pop_count = cnt;
`else
  assign pop_count = '0;
`endif

endmodule

// File: tb/tb_fifo_reader.sv
// Scoreboard bench for fifo_reader: a behavioural FIFO feeds the DUT, loaded words
// are queued as expectations and popped on every output handshake.
module tb_fifo_reader;
  import fifo_reader_pkg::*;

`ifdef FIFO_READER_STATS_EN
  localparam int STATS = 1;
`else
  localparam int STATS = 0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        drain_en = 1'b0;
  logic        clr_err = 1'b0;
  logic        fifo_empty;
  logic [15:0] fifo_data_out = 16'd0;
  logic        fifo_underflow = 1'b0;
  logic        fifo_rd_en;
  logic        m_valid;
  logic        m_ready = 1'b0;
  logic [15:0] m_data;
  logic        err_underflow;
  logic [15:0] pop_count;

  logic [15:0] fq [$];
  logic [15:0] exp_q [$];
  int          fcnt = 0;
  logic        force_uf = 1'b0;
  int          rd_cnt = 0;
  int          errors = 0;
  int          checks = 0;

  fifo_reader #(.FIFO_WIDTH(16), .FIFO_DEPTH(8)) dut (
    .clk            (clk),
    .rst            (rst),
    .drain_en       (drain_en),
    .clr_err        (clr_err),
    .fifo_empty     (fifo_empty),
    .fifo_data_out  (fifo_data_out),
    .fifo_underflow (fifo_underflow),
    .fifo_rd_en     (fifo_rd_en),
    .m_valid        (m_valid),
    .m_ready        (m_ready),
    .m_data         (m_data),
    .err_underflow  (err_underflow),
    .pop_count      (pop_count)
  );

  always #5 clk = ~clk;

  assign fifo_empty = (fcnt == 0);

  // Behavioural FIFO: registered read data and underflow flag.
  always @(posedge clk) begin
    if (fifo_rd_en) begin
      if (fcnt == 0 || force_uf) begin
        fifo_underflow <= 1'b1;
      end else begin
        fifo_data_out  <= fq.pop_front();
        fcnt           <= fcnt - 1;
        fifo_underflow <= 1'b0;
      end
    end else begin
      fifo_underflow <= 1'b0;
    end
  end

  // Output monitor: every handshake is scored against the expectation queue.
  always @(negedge clk) begin
    if (!rst) begin
      if (fifo_rd_en) rd_cnt = rd_cnt + 1;
      if (m_valid && m_ready) begin
        checks = checks + 1;
        if (exp_q.size() == 0) begin
          errors = errors + 1;
          $display("FAIL handshake_unexpected: got m_data=%h, required no word", m_data);
        end else begin
          logic [15:0] e;
          e = exp_q.pop_front();
          if (m_data !== e) begin
            errors = errors + 1;
            $display("FAIL handshake_data: got %h, required %h", m_data, e);
          end
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input logic [15:0] v, input bit expect_out);
    fq.push_back(v);
    fcnt = fcnt + 1;
    if (expect_out) exp_q.push_back(v);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    drain_en = 1'b0;
    m_ready = 1'b0;
    clr_err = 1'b0;
    force_uf = 1'b0;
    tick();
    fq.delete();
    fcnt = 0;
    exp_q.delete();
    tick();
    rst = 1'b0;
    rd_cnt = 0;
  endtask

  task automatic test_reset();
    do_reset();
    checks = checks + 1;
    if (m_valid !== 1'b0 || fifo_rd_en !== 1'b0 || err_underflow !== 1'b0) begin
      errors = errors + 1;
      $display("FAIL reset_ctrl: got valid=%b rd=%b err=%b, required 0 0 0", m_valid, fifo_rd_en, err_underflow);
    end
    checks = checks + 1;
    if (m_data !== 16'd0 || pop_count !== 16'd0) begin
      errors = errors + 1;
      $display("FAIL reset_data: got m_data=%h pop_count=%0d, required 0 0", m_data, pop_count);
    end
  endtask

  task automatic test_single();
    do_reset();
    load(16'hA5A5, 1'b1);
    drain_en = 1'b1;
    m_ready = 1'b1;
    tick();
    checks = checks + 1;
    if (fifo_rd_en !== 1'b1) begin
      errors = errors + 1;
      $display("FAIL single_rd: got %b, required 1", fifo_rd_en);
    end
    tick();
    checks = checks + 1;
    if (fifo_rd_en !== 1'b0 || m_valid !== 1'b0) begin
      errors = errors + 1;
      $display("FAIL single_n1: got rd=%b valid=%b, required 0 0", fifo_rd_en, m_valid);
    end
    tick();
    checks = checks + 1;
    if (m_valid !== 1'b1 || m_data !== 16'hA5A5) begin
      errors = errors + 1;
      $display("FAIL single_n2: got valid=%b data=%h, required 1 a5a5", m_valid, m_data);
    end
    tick();
    checks = checks + 1;
    if (m_valid !== 1'b0 || rd_cnt != 1 || exp_q.size() != 0) begin
      errors = errors + 1;
      $display("FAIL single_after: got valid=%b reads=%0d pending=%0d, required 0 1 0", m_valid, rd_cnt, exp_q.size());
    end
  endtask

  task automatic test_stream();
    int n;
    do_reset();
    for (int i = 1; i <= 8; i++) load(16'(i), 1'b1);
    m_ready = 1'b1;
    drain_en = 1'b1;
    n = 0;
    while (m_valid !== 1'b1 && n < 10) begin
      tick();
      n++;
    end
    for (int i = 1; i <= 8; i++) begin
      checks = checks + 1;
      if (m_valid !== 1'b1 || m_data !== 16'(i)) begin
        errors = errors + 1;
        $display("FAIL stream_word%0d: got valid=%b data=%h, required 1 %h", i, m_valid, m_data, 16'(i));
      end
      tick();
    end
    checks = checks + 1;
    if (m_valid !== 1'b0 || exp_q.size() != 0) begin
      errors = errors + 1;
      $display("FAIL stream_end: got valid=%b pending=%0d, required 0 0", m_valid, exp_q.size());
    end
    checks = checks + 1;
    if (pop_count !== ((STATS != 0) ? 16'd8 : 16'd0)) begin
      errors = errors + 1;
      $display("FAIL stream_pop_count: got %0d, required %0d", pop_count, (STATS != 0) ? 8 : 0);
    end
  endtask

  task automatic test_backpressure();
    int n;
    do_reset();
    for (int i = 1; i <= 8; i++) load(16'(i), 1'b1);
    m_ready = 1'b0;
    drain_en = 1'b1;
    for (int i = 0; i < 10; i++) tick();
    checks = checks + 1;
    if (rd_cnt != 3 || dut.occ !== 2'd3 || fcnt != 5) begin
      errors = errors + 1;
      $display("FAIL bp_credit: got reads=%0d occ=%0d fifo=%0d, required 3 3 5", rd_cnt, dut.occ, fcnt);
    end
    checks = checks + 1;
    if (m_valid !== 1'b1 || m_data !== 16'd1) begin
      errors = errors + 1;
      $display("FAIL bp_hold: got valid=%b data=%h, required 1 0001", m_valid, m_data);
    end
    m_ready = 1'b1;
    n = 0;
    while (exp_q.size() != 0 && n < 40) begin
      tick();
      n++;
    end
    tick();
    checks = checks + 1;
    if (exp_q.size() != 0 || rd_cnt != 8 || m_valid !== 1'b0) begin
      errors = errors + 1;
      $display("FAIL bp_release: got pending=%0d reads=%0d valid=%b, required 0 8 0", exp_q.size(), rd_cnt, m_valid);
    end
  endtask

  task automatic test_underflow();
    int n;
    int snap;
    do_reset();
    load(16'h1111, 1'b0);
    force_uf = 1'b1;
    m_ready = 1'b1;
    drain_en = 1'b1;
    n = 0;
    while (err_underflow !== 1'b1 && n < 10) begin
      tick();
      n++;
    end
    checks = checks + 1;
    if (err_underflow !== 1'b1 || dut.state !== ERROR) begin
      errors = errors + 1;
      $display("FAIL uf_enter: got err=%b state=%0d, required 1 %0d", err_underflow, dut.state, ERROR);
    end
    snap = rd_cnt;
    for (int i = 0; i < 5; i++) tick();
    checks = checks + 1;
    if (rd_cnt != snap || snap != 2 || m_valid !== 1'b0) begin
      errors = errors + 1;
      $display("FAIL uf_noread: got reads=%0d->%0d valid=%b, required 2->2 0", snap, rd_cnt, m_valid);
    end
    force_uf = 1'b0;
    drain_en = 1'b0;
    clr_err = 1'b1;
    tick();
    clr_err = 1'b0;
    checks = checks + 1;
    if (err_underflow !== 1'b0 || dut.state !== IDLE) begin
      errors = errors + 1;
      $display("FAIL uf_clear: got err=%b state=%0d, required 0 %0d", err_underflow, dut.state, IDLE);
    end
  endtask

  task automatic test_midreset();
    int n;
    do_reset();
    for (int i = 1; i <= 8; i++) load(16'(i), 1'b1);
    m_ready = 1'b0;
    drain_en = 1'b1;
    n = 0;
    while (!(dut.occ == 2'd2 && dut.inflight == 1'b1) && n < 10) begin
      tick();
      n++;
    end
    checks = checks + 1;
    if (dut.occ !== 2'd2 || dut.inflight !== 1'b1) begin
      errors = errors + 1;
      $display("FAIL mr_setup: got occ=%0d inflight=%b, required 2 1", dut.occ, dut.inflight);
    end
    rst = 1'b1;
    exp_q.delete();
    #1;
    checks = checks + 1;
    if (m_valid !== 1'b0 || fifo_rd_en !== 1'b0) begin
      errors = errors + 1;
      $display("FAIL mr_rst_cycle: got valid=%b rd=%b, required 0 0", m_valid, fifo_rd_en);
    end
    tick();
    rst = 1'b0;
    #1;
    checks = checks + 1;
    if (m_valid !== 1'b0 || fifo_rd_en !== 1'b0 || pop_count !== 16'd0) begin
      errors = errors + 1;
      $display("FAIL mr_after: got valid=%b rd=%b pop_count=%0d, required 0 0 0", m_valid, fifo_rd_en, pop_count);
    end
    drain_en = 1'b0;
    tick();
    checks = checks + 1;
    if (dut.occ !== 2'd0 || m_valid !== 1'b0) begin
      errors = errors + 1;
      $display("FAIL mr_nocapture: got occ=%0d valid=%b, required 0 0", dut.occ, m_valid);
    end
  endtask

  task automatic test_drain();
    int n;
    do_reset();
    for (int i = 1; i <= 4; i++) load(16'(16'h40 + i), 1'b1);
    m_ready = 1'b1;
    drain_en = 1'b1;
    n = 0;
    while (fifo_rd_en !== 1'b1 && n < 10) begin
      tick();
      n++;
    end
    tick();
    drain_en = 1'b0;
    for (int i = 0; i < 6; i++) tick();
    checks = checks + 1;
    if (rd_cnt != 1 || exp_q.size() != 3 || m_valid !== 1'b0) begin
      errors = errors + 1;
      $display("FAIL drain_off: got reads=%0d pending=%0d valid=%b, required 1 3 0", rd_cnt, exp_q.size(), m_valid);
    end
    drain_en = 1'b1;
    n = 0;
    while (exp_q.size() != 0 && n < 30) begin
      tick();
      n++;
    end
    checks = checks + 1;
    if (exp_q.size() != 0 || rd_cnt != 4) begin
      errors = errors + 1;
      $display("FAIL drain_resume: got pending=%0d reads=%0d, required 0 4", exp_q.size(), rd_cnt);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_stream();
    test_backpressure();
    test_underflow();
    test_midreset();
    test_drain();
    tick();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
